// File: rtl/slink_attr_sequencer.sv
// Attribute command sequencer: pops software commands from the send FIFO, issues
// them on the link request channel and pushes read responses into the receive FIFO.
module slink_attr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_WIDTH  = 16,
  parameter logic [15:0] TIMEOUT_RDATA  = 16'hDEAD
) (
  input  logic        link_clk,
  input  logic        link_reset,
  input  logic        enable,
  input  logic        send_fifo_empty,
  input  logic [15:0] send_attr_addr,
  input  logic [15:0] send_attr_wdata,
  input  logic        send_attr_wr,
  output logic        send_fifo_rinc,
  output logic        attr_req_valid,
  input  logic        attr_req_ready,
  output logic [15:0] attr_req_addr,
  output logic [15:0] attr_req_wdata,
  output logic        attr_req_wr,
  input  logic        attr_rsp_valid,
  input  logic [15:0] attr_rsp_rdata,
  input  logic        recv_fifo_full,
  output logic        recv_fifo_winc,
  output logic [15:0] recv_attr_rdata,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_stray_rsp,
  input  logic        status_clear,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_PUSH
  } state_t;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 32'd1 : 32'd0);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_timer;
  logic [15:0]              r_req_addr;
  logic [15:0]              r_req_wdata;
  logic                     r_req_wr;
  logic [15:0]              r_recv_rdata;
  logic                     r_err_timeout;
  logic                     r_err_stray;
  logic [15:0]              r_txn_count;

  logic w_pop;
  logic w_req_fire;
  logic w_rsp_fire;
  logic w_timeout_fire;
  logic w_push;
  logic w_stray;
  logic w_txn_inc;

  // The pop is gated by reset so a command is never consumed while the block is held in reset.
  assign w_pop          = (r_state == S_IDLE) && enable && !send_fifo_empty && link_reset;
  assign w_req_fire     = (r_state == S_REQ) && attr_req_ready;
  assign w_rsp_fire     = (r_state == S_WAIT_RSP) && attr_rsp_valid;
  assign w_timeout_fire = (r_state == S_WAIT_RSP) && !attr_rsp_valid &&
                          TIMEOUT_EN && (r_timer == TIMER_LAST);
  assign w_push         = (r_state == S_PUSH) && !recv_fifo_full;
  assign w_stray        = attr_rsp_valid && (r_state != S_WAIT_RSP);
  assign w_txn_inc      = (w_req_fire && r_req_wr) || w_push;

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_pop) w_state_nxt = S_REQ;
      S_REQ:      if (w_req_fire) w_state_nxt = r_req_wr ? S_IDLE : S_WAIT_RSP;
      S_WAIT_RSP: if (w_rsp_fire || w_timeout_fire) w_state_nxt = S_PUSH;
      S_PUSH:     if (w_push) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge link_clk or negedge link_reset) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!link_reset) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge link_clk or negedge link_reset) begin
    if (!link_reset) begin
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wr    <= 1'b0;
    end else if (w_pop) begin
      r_req_addr  <= send_attr_addr;
      r_req_wdata <= send_attr_wdata;
      r_req_wr    <= send_attr_wr;
    end
  end

  // Timer free-runs in WAIT_RSP; it is only compared when the timeout is enabled.
  always_ff @(posedge link_clk or negedge link_reset) begin
    if (!link_reset)                r_timer <= '0;
    else if (w_req_fire)            r_timer <= '0;
    else if (r_state == S_WAIT_RSP) r_timer <= r_timer + TIMEOUT_WIDTH'(1);
  end

  always_ff @(posedge link_clk or negedge link_reset) begin
    if (!link_reset)         r_recv_rdata <= '0;
    else if (w_rsp_fire)     r_recv_rdata <= attr_rsp_rdata;
    else if (w_timeout_fire) r_recv_rdata <= TIMEOUT_RDATA;
  end

  // A set event in the same cycle as status_clear wins; the count restarts from the increment.
  always_ff @(posedge link_clk or negedge link_reset) begin
    if (!link_reset) begin
      r_err_timeout <= 1'b0;
      r_err_stray   <= 1'b0;
      r_txn_count   <= '0;
    end else begin
      r_err_timeout <= w_timeout_fire || (r_err_timeout && !status_clear);
      r_err_stray   <= w_stray || (r_err_stray && !status_clear);
      r_txn_count   <= (status_clear ? 16'd0 : r_txn_count) + {15'd0, w_txn_inc};
    end
  end

  assign send_fifo_rinc  = w_pop;
  assign attr_req_valid  = (r_state == S_REQ);
  assign attr_req_addr   = r_req_addr;
  assign attr_req_wdata  = r_req_wdata;
  assign attr_req_wr     = r_req_wr;
  assign recv_fifo_winc  = w_push;
  assign recv_attr_rdata = r_recv_rdata;
  assign busy            = (r_state != S_IDLE);
  assign err_timeout     = r_err_timeout;
  assign err_stray_rsp   = r_err_stray;
  assign txn_count       = r_txn_count;

endmodule

// File: tb/tb_slink_attr_sequencer.sv
// Directed bench for slink_attr_sequencer: a cycle table for a write and a stalled
// read, then hand sequences for timeout, full FIFO, stray responses, reset and enable.
module tb_slink_attr_sequencer;

  logic        link_clk = 1'b0;
  logic        link_reset;
  logic        enable, send_fifo_empty, send_attr_wr, send_fifo_rinc;
  logic [15:0] send_attr_addr, send_attr_wdata;
  logic        attr_req_valid, attr_req_ready, attr_req_wr;
  logic [15:0] attr_req_addr, attr_req_wdata;
  logic        attr_rsp_valid;
  logic [15:0] attr_rsp_rdata;
  logic        recv_fifo_full, recv_fifo_winc;
  logic [15:0] recv_attr_rdata;
  logic        busy, err_timeout, err_stray_rsp, status_clear;
  logic [15:0] txn_count;

  int total = 0;
  int bad   = 0;

  always #5 link_clk = ~link_clk;

  slink_attr_sequencer #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_WIDTH (16),
    .TIMEOUT_RDATA (16'hDEAD)
  ) dut (
    .link_clk       (link_clk),
    .link_reset     (link_reset),
    .enable         (enable),
    .send_fifo_empty(send_fifo_empty),
    .send_attr_addr (send_attr_addr),
    .send_attr_wdata(send_attr_wdata),
    .send_attr_wr   (send_attr_wr),
    .send_fifo_rinc (send_fifo_rinc),
    .attr_req_valid (attr_req_valid),
    .attr_req_ready (attr_req_ready),
    .attr_req_addr  (attr_req_addr),
    .attr_req_wdata (attr_req_wdata),
    .attr_req_wr    (attr_req_wr),
    .attr_rsp_valid (attr_rsp_valid),
    .attr_rsp_rdata (attr_rsp_rdata),
    .recv_fifo_full (recv_fifo_full),
    .recv_fifo_winc (recv_fifo_winc),
    .recv_attr_rdata(recv_attr_rdata),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .err_stray_rsp  (err_stray_rsp),
    .status_clear   (status_clear),
    .txn_count      (txn_count)
  );

  typedef struct packed {
    logic        en, emp, wr, rdy, rsp, full, clr;
    logic [15:0] addr, wdata, rdata;
  } in_t;

  typedef struct packed {
    logic        rinc, vld, wr;
    logic [15:0] addr, wdata;
    logic        winc;
    logic [15:0] rdata;
    logic        busy, eto, estr;
    logic [15:0] txn;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t out;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    return '{send_fifo_rinc, attr_req_valid, attr_req_wr, attr_req_addr, attr_req_wdata,
             recv_fifo_winc, recv_attr_rdata, busy, err_timeout, err_stray_rsp, txn_count};
  endfunction

  task automatic apply(input in_t v);
    enable = v.en; send_fifo_empty = v.emp; send_attr_wr = v.wr; attr_req_ready = v.rdy;
    attr_rsp_valid = v.rsp; recv_fifo_full = v.full; status_clear = v.clr;
    send_attr_addr = v.addr; send_attr_wdata = v.wdata; attr_rsp_rdata = v.rdata;
  endtask

  task automatic idle_in();
    apply('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0});
  endtask

  task automatic settle();
    @(negedge link_clk);
  endtask

  task automatic adv();
    @(posedge link_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    in_t  i_idle;
    out_t o_req_rd, o_wait_rd;

    link_reset = 1'b0;
    apply('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0});
    repeat (2) @(posedge link_clk);
    #1 link_reset = 1'b1;

    // Columns: in = en emp wr rdy rsp full clr addr wdata rdata
    //          out = rinc vld wr addr wdata winc rdata busy eto estr txn
    i_idle    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0};
    o_req_rd  = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd1};
    o_wait_rd = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs.push_back('{'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0},
                     '{1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'd0}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 16'h0},
                     '{1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'd0}});
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0},
                     '{1'b0, 1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd0}});
    vecs.push_back('{i_idle,
                     '{1'b0, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'd1}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h0},
                     '{1'b1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'd1}});
    repeat (3) vecs.push_back('{i_idle, o_req_rd});
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0}, o_req_rd});
    repeat (5) vecs.push_back('{i_idle, o_wait_rd});
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234}, o_wait_rd});
    vecs.push_back('{i_idle,
                     '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'd1}});
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0},
                     '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 16'd2}});
    vecs.push_back('{i_idle,
                     '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 16'd0}});

    foreach (vecs[i]) begin
      apply(vecs[i].in);
      settle();
      check($sformatf("vec%0d", i), 80'(sample()), 80'(vecs[i].out));
      adv();
    end

    // Timeout: PUSH must appear after exactly 8 WAIT_RSP cycles.
    idle_in(); send_fifo_empty = 1'b0; send_attr_addr = 16'h0030; settle(); adv();
    idle_in(); attr_req_ready = 1'b1; settle(); adv();
    idle_in(); n = 0; settle();
    while (!recv_fifo_winc && n < 50) begin
      adv(); n++; settle();
    end
    check("timeout_wait_cycles", 80'(n), 80'(8));
    check("timeout_rdata", 80'(recv_attr_rdata), 80'(16'hDEAD));
    check("timeout_flag", 80'(err_timeout), 80'(1));
    adv(); settle();
    check("timeout_txn", 80'(txn_count), 80'(1));
    adv(); status_clear = 1'b1; settle(); adv();
    idle_in(); settle();
    check("timeout_cleared", 80'({err_timeout, txn_count}), 80'({1'b0, 16'd0}));
    adv();

    // Receive FIFO full: response held in PUSH, no push until full drops.
    idle_in(); send_fifo_empty = 1'b0; send_attr_addr = 16'h0040; settle(); adv();
    idle_in(); attr_req_ready = 1'b1; settle(); adv();
    idle_in(); attr_rsp_valid = 1'b1; attr_rsp_rdata = 16'h5A5A; recv_fifo_full = 1'b1;
    settle(); adv();
    idle_in(); recv_fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("full_hold%0d", k), 80'({recv_fifo_winc, busy}), 80'({1'b0, 1'b1}));
      adv();
    end
    idle_in(); settle();
    check("full_release", 80'({recv_fifo_winc, recv_attr_rdata}), 80'({1'b1, 16'h5A5A}));
    adv(); settle();
    check("full_done", 80'({recv_fifo_winc, busy, txn_count}), 80'({1'b0, 1'b0, 16'd1}));
    adv();

    // Stray response in IDLE, then the same with a concurrent clear (set wins).
    idle_in(); attr_rsp_valid = 1'b1; attr_rsp_rdata = 16'hBEEF; settle(); adv();
    idle_in(); settle();
    check("stray_idle", 80'({err_stray_rsp, busy, recv_attr_rdata}), 80'({1'b1, 1'b0, 16'h5A5A}));
    adv();
    idle_in(); attr_rsp_valid = 1'b1; status_clear = 1'b1; settle(); adv();
    idle_in(); settle();
    check("stray_vs_clear", 80'({err_stray_rsp, txn_count}), 80'({1'b1, 16'd0}));
    adv();

    // Response on the timeout cycle: the response wins.
    idle_in(); send_fifo_empty = 1'b0; send_attr_addr = 16'h0050; settle(); adv();
    idle_in(); attr_req_ready = 1'b1; settle(); adv();
    idle_in(); repeat (7) begin settle(); adv(); end
    idle_in(); attr_rsp_valid = 1'b1; attr_rsp_rdata = 16'h7777; settle(); adv();
    idle_in(); settle();
    check("coincide_push", 80'({recv_fifo_winc, recv_attr_rdata, err_timeout}),
          80'({1'b1, 16'h7777, 1'b0}));
    adv();

    // Reset asserted during WAIT_RSP clears everything at once.
    idle_in(); send_fifo_empty = 1'b0; send_attr_addr = 16'h0060; settle(); adv();
    idle_in(); attr_req_ready = 1'b1; settle(); adv();
    idle_in(); settle(); adv(); settle();
    send_fifo_empty = 1'b0;
    link_reset = 1'b0;
    #1;
    check("reset_outputs", 80'(sample()), 80'(0));
    adv();
    link_reset = 1'b1;

    // Two queued writes held back by enable=0, then popped 2 cycles apart.
    idle_in(); enable = 1'b0; send_fifo_empty = 1'b0; send_attr_wr = 1'b1;
    send_attr_addr = 16'h0100;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("enable_off%0d", k), 80'({send_fifo_rinc, busy}), 80'(0));
      adv();
    end
    begin
      logic [15:0] addrs [2];
      int qn, pops;
      int rinc_at [2];
      addrs[0] = 16'h0100; addrs[1] = 16'h0200;
      qn = 2; pops = 0; rinc_at[0] = -10; rinc_at[1] = -10;
      for (int c = 0; c < 8; c++) begin
        idle_in();
        send_attr_wr = 1'b1; attr_req_ready = 1'b1;
        send_fifo_empty = (qn <= 0);
        if (qn > 0) begin
          send_attr_addr  = addrs[2-qn];
          send_attr_wdata = ~addrs[2-qn];
        end
        status_clear = (pops == 2) && (rinc_at[1] == c - 1);
        settle();
        if (attr_req_valid && pops >= 1 && pops <= 2)
          check($sformatf("b2b_req_addr%0d", pops), 80'({attr_req_addr, attr_req_wdata}),
                80'({addrs[pops-1], ~addrs[pops-1]}));
        if (send_fifo_rinc) begin
          if (pops < 2) rinc_at[pops] = c;
          pops++;
          qn--;
        end
        adv();
      end
      check("b2b_pops", 80'(pops), 80'(2));
      check("b2b_spacing", 80'(rinc_at[1] - rinc_at[0]), 80'(2));
      settle();
      check("b2b_txn_clear_inc", 80'(txn_count), 80'(1));
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slink_attr_sequencer.md
Name: slink_attr_sequencer

Overview:
- Link-clock-domain engine directly downstream of the attribute send FIFO and upstream of the attribute receive FIFO.
- Pops one software attribute command per transaction from the send FIFO and issues it to the link layer over a valid/ready request channel.
- For reads, waits for the link response, or a timeout, then pushes the 16-bit read data into the receive FIFO. Tracks sticky error flags and a completed-transaction count for software.

Parameters:
- TIMEOUT_CYCLES, 1024: response wait limit in link_clk cycles; 0 disables the timeout.
- TIMEOUT_WIDTH, 16: timer width; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_WIDTH.
- TIMEOUT_RDATA, 16'hDEAD: read data pushed on a timed-out read.

Ports:
- link_clk  in  1  sole clock.
- link_reset  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new command is popped; an in-flight transaction still completes.
- send_fifo_empty  in  1  send FIFO empty.
- send_attr_addr  in  16  head-of-FIFO address; valid when send_fifo_empty=0.
- send_attr_wdata  in  16  head-of-FIFO write data.
- send_attr_wr  in  1  head-of-FIFO type: 1=write, 0=read.
- send_fifo_rinc  out  1  one-cycle pop pulse.
- attr_req_valid  out  1  request valid.
- attr_req_ready  in  1  link layer accepts the request.
- attr_req_addr  out  16  registered request address.
- attr_req_wdata  out  16  registered request write data.
- attr_req_wr  out  1  registered request type.
- attr_rsp_valid  in  1  one-cycle read-response strobe.
- attr_rsp_rdata  in  16  response data.
- recv_fifo_full  in  1  receive FIFO full.
- recv_fifo_winc  out  1  one-cycle push pulse.
- recv_attr_rdata  out  16  registered push data.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky: a read timed out.
- err_stray_rsp  out  1  sticky: attr_rsp_valid arrived outside WAIT_RSP.
- status_clear  in  1  synchronous clear of both sticky flags and txn_count.
- txn_count  out  16  completed transactions, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (link_reset=0, asynchronous): state IDLE; all outputs 0, including req fields, recv_attr_rdata, flags and txn_count; timer 0.
- IDLE: if enable=1 and send_fifo_empty=0:
  - capture addr/wdata/wr into the req registers;
  - drive send_fifo_rinc=1 for exactly that cycle;
  - go to REQ.
- REQ: attr_req_valid=1; fields held stable until accepted. On attr_req_ready=1:
  - if wr=1: txn_count+1, go to IDLE;
  - else: clear timer, go to WAIT_RSP.
- attr_req_valid never drops before acceptance; ready while not in REQ is ignored.
- WAIT_RSP: timer increments every cycle.
  - attr_rsp_valid=1: latch attr_rsp_rdata into recv_attr_rdata, go to PUSH.
  - Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: load TIMEOUT_RDATA, set err_timeout, go to PUSH.
  - A response and the timeout in the same cycle: the response wins and err_timeout is not set.
- PUSH: if recv_fifo_full=0, drive recv_fifo_winc=1 for one cycle, txn_count+1, go to IDLE. Otherwise hold in PUSH with data stable; an overflowing push is never issued.
- attr_rsp_valid in IDLE, REQ or PUSH: set err_stray_rsp; data discarded; state unaffected.
- status_clear: clears err_timeout, err_stray_rsp and txn_count. If a set event occurs in the same cycle, the set wins for the flag; txn_count goes to 0, then the increment is applied, giving 1.
- Deassertion of enable mid-transaction has no effect until the FSM returns to IDLE.
- Throughput:
  - write: 2 cycles minimum (IDLE, REQ with ready=1); back-to-back writes pop every 2 cycles;
  - read: 4 cycles minimum (IDLE, REQ, WAIT_RSP, PUSH).
- busy=1 in REQ, WAIT_RSP and PUSH.
- Reset asserted mid-operation: immediate return to the IDLE/zero state. A popped but unissued command is lost; this is documented and acceptable.

Test Plan:
- Single write (addr=16'h0010, wdata=16'hA5A5, wr=1), ready=1 on first REQ cycle -> rinc pulse at cycle 0, req_valid at cycle 1 with matching fields, no recv push, txn_count=1.
- Read addr=16'h0020, ready delayed 3 cycles, rsp_valid with rdata=16'h1234 after 5 WAIT cycles -> req fields stable throughout the stall; recv_fifo_winc one cycle carrying 16'h1234; txn_count=1.
- Read with no response, TIMEOUT_CYCLES=8 -> PUSH entered after exactly 8 WAIT cycles, data 16'hDEAD, err_timeout=1; status_clear returns it to 0.
- Read response while recv_fifo_full=1 for 4 cycles -> no winc while full; single winc the cycle after full drops; busy stays 1 throughout.
- rsp_valid pulse in IDLE, plus a response coinciding with the timeout cycle -> err_stray_rsp=1, err_timeout=0, the response data is pushed.
- Reset asserted during WAIT_RSP; enable=0 with 2 queued commands -> all outputs 0 immediately on reset; with enable=0 no rinc, and after enable=1 the two commands pop 2 cycles apart (writes).
